button_stimulus_gen: RTL

Synchronous generator that plays button gestures (single click, double click, timed hold) onto an active-low button line. It drives the same physical-style `din` waveform that the button controller decodes into press/unpress/autorep/double events. It is used for on-board self-test and demo sequencing, sitting between a command source and the controller's `din` input. One command is accepted at a time through a valid/ready handshake, and completion is reported with a `done` pulse.

---
 rtl/button_pkg.sv | 35 +++
 rtl/btn_interval_timer.sv | 34 +++
 rtl/button_stimulus_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared encodings, state type and cycle-count helpers for the button stimulus generator
package button_pkg;

   // Gesture opcodes carried on cmd_op
   typedef enum logic [1:0] {
      OP_CLICK  = 2'b00,
      OP_DOUBLE = 2'b01,
      OP_HOLD   = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   // Gesture sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      GAP    = 3'd2,
      PRESS2 = 3'd3,
      HOLD   = 3'd4,
      TAIL   = 3'd5
   } state_e;

   localparam int unsigned CNT_W = 32;

   // Clock cycles per millisecond
   function automatic longint unsigned tick_of(input longint unsigned clk_hz);
      return clk_hz / 64'd1000;
   endfunction

   // Milliseconds to clock cycles, evaluated at elaboration only
   function automatic longint unsigned ms_cycles(input longint unsigned ms,
                                                 input longint unsigned tick);
      return ms * tick;
   endfunction

endpackage

// File: rtl/btn_interval_timer.sv
// rtl/btn_interval_timer.sv - down-counter that flags the last cycle of a loaded interval
module btn_interval_timer
   import button_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] count,
   output logic             expired
);

   logic [CNT_W-1:0] remain;
   logic             active;

   // Count the interval down; a load overrides a running interval, clear overrides everything
   always_ff @(posedge clk) begin
      if (clear) begin
         remain <= '0;
         active <= 1'b0;
      end else if (load) begin
         // A zero length is run as a single cycle rather than wrapping
         remain <= (count == '0) ? '0 : count - {{(CNT_W-1){1'b0}}, 1'b1};
         active <= 1'b1;
      end else if (active) begin
         if (remain == '0)
            active <= 1'b0;
         else
            remain <= remain - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign expired = active && (remain == '0);

endmodule

// File: rtl/button_stimulus_gen.sv
// rtl/button_stimulus_gen.sv - plays click, double-click and hold gestures onto an active-low button line
module button_stimulus_gen
   import button_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned PRESS_MS     = 100,
   parameter int unsigned GAP_MS       = 150,
   parameter int unsigned HOLD_UNIT_MS = 100,
   parameter int unsigned RELEASE_MS   = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_len,
   input  logic       abort,
   output logic       dout,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam longint unsigned TICK  = tick_of(64'(CLK_HZ));
   localparam longint unsigned P64   = ms_cycles(64'(PRESS_MS), TICK);
   localparam longint unsigned G64   = ms_cycles(64'(GAP_MS), TICK);
   localparam longint unsigned U64   = ms_cycles(64'(HOLD_UNIT_MS), TICK);
   localparam longint unsigned R64   = ms_cycles(64'(RELEASE_MS), TICK);
   localparam longint unsigned LIMIT = 64'h1_0000_0000;

   localparam logic [CNT_W-1:0] P_CYC = CNT_W'(P64);
   localparam logic [CNT_W-1:0] G_CYC = CNT_W'(G64);
   localparam logic [CNT_W-1:0] U_CYC = CNT_W'(U64);
   localparam logic [CNT_W-1:0] R_CYC = CNT_W'(R64);

   // Reject clock/duration settings the 32-bit counter cannot represent
   if (TICK < 64'd1) begin : g_bad_tick
      $error("button_stimulus_gen: CLK_HZ gives less than one cycle per ms");
   end
   if ((64'd255 * U64) >= LIMIT || P64 >= LIMIT || G64 >= LIMIT || R64 >= LIMIT) begin : g_bad_range
      $error("button_stimulus_gen: gesture duration exceeds the 32-bit counter");
   end

   state_e           state, nxt;
   op_e              op_q;
   logic [7:0]       units_left, units_nxt;
   logic             tmr_load, tmr_expired;
   logic [CNT_W-1:0] tmr_count;
   logic             accept;

   assign accept = cmd_valid && cmd_ready;

   btn_interval_timer u_timer (
      .clk     (clk),
      .clear   (reset),
      .load    (tmr_load),
      .count   (tmr_count),
      .expired (tmr_expired)
   );

   // Next gesture step and timer reload on every state entry; holds are replayed as L unit intervals
   always_comb begin
      nxt       = state;
      tmr_load  = 1'b0;
      tmr_count = R_CYC;
      units_nxt = units_left;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op_e'(cmd_op))
                  OP_CLICK, OP_DOUBLE: begin
                     nxt       = PRESS1;
                     tmr_load  = 1'b1;
                     tmr_count = P_CYC;
                  end
                  OP_HOLD: begin
                     nxt       = HOLD;
                     tmr_load  = 1'b1;
                     tmr_count = U_CYC;
                     units_nxt = (cmd_len == 8'd0) ? 8'd1 : cmd_len;
                  end
                  default: ;
               endcase
            end
         end
         PRESS1: begin
            if (abort) begin
               nxt      = TAIL;
               tmr_load = 1'b1;
            end else if (tmr_expired) begin
               tmr_load = 1'b1;
               if (op_q == OP_DOUBLE) begin
                  nxt       = GAP;
                  tmr_count = G_CYC;
               end else begin
                  nxt = TAIL;
               end
            end
         end
         GAP: begin
            if (abort) begin
               nxt      = TAIL;
               tmr_load = 1'b1;
            end else if (tmr_expired) begin
               nxt       = PRESS2;
               tmr_load  = 1'b1;
               tmr_count = P_CYC;
            end
         end
         PRESS2: begin
            if (abort || tmr_expired) begin
               nxt      = TAIL;
               tmr_load = 1'b1;
            end
         end
         HOLD: begin
            if (abort) begin
               nxt      = TAIL;
               tmr_load = 1'b1;
            end else if (tmr_expired) begin
               tmr_load = 1'b1;
               if (units_left <= 8'd1) begin
                  nxt = TAIL;
               end else begin
                  tmr_count = U_CYC;
                  units_nxt = units_left - 8'd1;
               end
            end
         end
         TAIL: begin
            if (tmr_expired)
               nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // State register with all outputs registered from the next state so the button line never glitches
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= OP_CLICK;
         units_left <= 8'd0;
         dout       <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         state      <= nxt;
         units_left <= units_nxt;
         if (accept)
            op_q <= op_e'(cmd_op);
         dout      <= !((nxt == PRESS1) || (nxt == PRESS2) || (nxt == HOLD));
         busy      <= (nxt != IDLE);
         cmd_ready <= (nxt == IDLE);
         done      <= (state == TAIL) && (nxt == IDLE);
         err       <= accept && (op_e'(cmd_op) == OP_RSVD);
      end
   end

endmodule
